axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter DATA_W, default 8: AXI data width in bits; legal values 8, 16, 32.
REQ-002 Parameter ADDR_W, default 32: AXI address width in bits.
REQ-003 Parameter DEPTH, default 256: number of DATA_W-bit words held; power of two.
REQ-004 Parameter RD_LATENCY, default 1: idle cycles inserted between AR handshake and R valid; range 0..15.
REQ-005 Ports, in order: clk in 1 clock; m_aresetn in 1 asynchronous active-low reset; one clock domain only.
REQ-006 AR channel: m_axi_araddr in ADDR_W; m_axi_arsize in 3; m_axi_arvalid in 1; m_axi_arready out 1.
REQ-007 R channel: m_axi_rdata out DATA_W; m_axi_rresp out 2; m_axi_rvalid out 1; m_axi_rready in 1.
REQ-008 AW channel: m_axi_awaddr in ADDR_W; m_axi_awsize in 3; m_axi_awvalid in 1; m_axi_awready out 1.
REQ-009 W channel: m_axi_wdata in DATA_W; m_axi_wstrb in DATA_W/8; m_axi_wvalid in 1; m_axi_wready out 1.
REQ-010 B channel: m_axi_bresp out 2; m_axi_bvalid out 1; m_axi_bready in 1.

Function
REQ-011 FSM states SHALL be IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP; exactly one transaction in flight.
REQ-012 arready and awready SHALL be high only in IDLE; wready SHALL be high in WR_DATA, and in IDLE only when awvalid is also high.
REQ-013 IDLE with only arvalid: AR handshake; go to RD_WAIT when RD_LATENCY>0, else RD_RESP.
REQ-014 IDLE with arvalid and awvalid both high: grant the channel not granted last; after reset, read wins first.
REQ-015 RD_WAIT SHALL count RD_LATENCY cycles, then enter RD_RESP; rvalid rises exactly 1+RD_LATENCY cycles after the AR handshake.
REQ-016 RD_RESP: rvalid high, rdata/rresp stable until the rready handshake, then IDLE; rvalid never drops without rready.
REQ-017 Word index = addr >> log2(DATA_W/8); low address bits ignored.
REQ-018 Error condition: index >= DEPTH, or size > log2(DATA_W/8); response SLVERR (2'b10), else OKAY (2'b00).
REQ-019 Errored read returns rdata = 0; errored write SHALL not modify memory.
REQ-020 IDLE with awvalid and wvalid: both handshake same cycle, go to WR_RESP; awvalid alone: capture address, go to WR_DATA.
REQ-021 Write SHALL update only bytes whose wstrb bit is 1; wstrb = 0 is OKAY with no change.
REQ-022 WR_RESP: bvalid high the cycle after the W handshake, held with stable bresp until bready, then IDLE.
REQ-023 A read issued the cycle after a write's B handshake to the same address SHALL return the new data.
REQ-024 Memory contents SHALL survive reset; never-written words read as 0 (memory zero-initialised at configuration).

Reset
REQ-025 m_aresetn low SHALL immediately force state IDLE and clear the latency counter, arbitration flag, and captured address.
REQ-026 During reset: arready, awready, wready, rvalid, bvalid = 0; rdata = 0; rresp = bresp = OKAY.
REQ-027 Reset asserted mid-transaction SHALL abandon it with no response; a pending write with no W handshake leaves memory unchanged.
REQ-028 Release SHALL be synchronised in use: the first handshake is possible on the second rising clk edge after deassertion.

Structure
REQ-029 Shared package axi_pkg SHALL hold the response constants OKAY/SLVERR and the FSM state typedef.
REQ-030 Storage SHALL be one sub-module axi_mem_ram: DEPTH x DATA_W, byte-enable write, one-cycle registered read.
REQ-031 No logic outside the single clk domain; RD_LATENCY and DEPTH checked at elaboration.

Verification
REQ-032 DATA_W=32, write 0xDEADBEEF to 0x10 with wstrb 0xF, then read 0x10 -> bresp OKAY, rdata 0xDEADBEEF, rresp OKAY.
REQ-033 RD_LATENCY=3, AR handshake at cycle t -> rvalid first high at cycle t+4; rready held low 5 cycles -> rvalid and rdata stable throughout.
REQ-034 DEPTH=256, DATA_W=8, read 0x100 -> rresp 2'b10, rdata 0; write 0x100 then read 0x00 -> 0x00 unchanged.
REQ-035 DATA_W=32, write 0x11223344 to 0x0, then write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
REQ-036 arvalid and awvalid raised together twice in succession -> grant order read, write, read, write.
REQ-037 awvalid accepted, wvalid withheld, reset pulsed -> all outputs 0; read of that address returns prior value.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response codes and responder FSM states.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } axi_state_e;

endpackage

// File: rtl/axi_mem_ram.sv
// DEPTH x DATA_W storage built from independent byte lanes: byte-enable write, registered read.
module axi_mem_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    // No reset on storage: contents persist across m_aresetn, and the block RAM
    // powers up zero-filled on the target device.
    generate
        for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (we && wstrb[gi]) begin
                    lane_mem[waddr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    lane_q <= lane_mem[raddr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI-lite style memory responder with fixed read latency and SLVERR checking.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  m_aresetn,
    input  logic [ADDR_W-1:0]     m_axi_araddr,
    input  logic [2:0]            m_axi_arsize,
    input  logic                  m_axi_arvalid,
    output logic                  m_axi_arready,
    output logic [DATA_W-1:0]     m_axi_rdata,
    output logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    input  logic [ADDR_W-1:0]     m_axi_awaddr,
    input  logic [2:0]            m_axi_awsize,
    input  logic                  m_axi_awvalid,
    output logic                  m_axi_awready,
    input  logic [DATA_W-1:0]     m_axi_wdata,
    input  logic [DATA_W/8-1:0]   m_axi_wstrb,
    input  logic                  m_axi_wvalid,
    output logic                  m_axi_wready,
    output logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bvalid,
    input  logic                  m_axi_bready
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    generate
        if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
            $error("axi_mem_responder: DATA_W must be 8, 16 or 32");
        end
        if (RD_LATENCY < 0 || RD_LATENCY > 15) begin : g_bad_latency
            $error("axi_mem_responder: RD_LATENCY must be within 0..15");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axi_mem_responder: DEPTH must be a power of two >= 2");
        end
        if (ADDR_W < BYTE_SH + IDX_W) begin : g_bad_addr_w
            $error("axi_mem_responder: ADDR_W too narrow for DEPTH");
        end
    endgenerate

    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
        logic [ADDR_W-1:0] idx;
        idx = addr >> BYTE_SH;
        return (idx >= ADDR_W'(DEPTH)) || (size > 3'(BYTE_SH));
    endfunction

    axi_state_e        state_reg, state_next;
    logic [3:0]        lat_cnt_reg, lat_cnt_next;
    logic              prio_wr_reg, prio_wr_next;
    logic [IDX_W-1:0]  widx_reg, widx_next;
    logic              wr_err_reg, wr_err_next;
    logic              rd_err_reg, rd_err_next;
    logic [1:0]        bresp_reg, bresp_next;
    logic              run_reg;

    logic              grant_rd, grant_wr, ar_err, aw_err;
    logic              ram_we, ram_re;
    logic [IDX_W-1:0]  ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    assign ram_raddr = m_axi_araddr[BYTE_SH +: IDX_W];

    axi_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wstrb (m_axi_wstrb),
        .waddr (ram_waddr),
        .wdata (m_axi_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // run_reg holds off all handshakes until the first edge after reset release.
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= '0;
            prio_wr_reg <= 1'b0;
            widx_reg    <= '0;
            wr_err_reg  <= 1'b0;
            rd_err_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            run_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            prio_wr_reg <= prio_wr_next;
            widx_reg    <= widx_next;
            wr_err_reg  <= wr_err_next;
            rd_err_reg  <= rd_err_next;
            bresp_reg   <= bresp_next;
            run_reg     <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lat_cnt_next  = lat_cnt_reg;
        prio_wr_next  = prio_wr_reg;
        widx_next     = widx_reg;
        wr_err_next   = wr_err_reg;
        rd_err_next   = rd_err_reg;
        bresp_next    = bresp_reg;
        m_axi_arready = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;
        ram_re        = 1'b0;
        ram_we        = 1'b0;
        ram_waddr     = m_axi_awaddr[BYTE_SH +: IDX_W];
        ar_err        = addr_err(m_axi_araddr, m_axi_arsize);
        aw_err        = addr_err(m_axi_awaddr, m_axi_awsize);

        case (state_reg)
            IDLE: begin
                if (run_reg) begin
                    // On a tie the channel that lost last time wins.
                    grant_rd      = m_axi_arvalid && (!m_axi_awvalid || !prio_wr_reg);
                    grant_wr      = m_axi_awvalid && !grant_rd;
                    m_axi_arready = !grant_wr;
                    m_axi_awready = !grant_rd;
                    m_axi_wready  = grant_wr;
                    if (grant_rd) begin
                        ram_re       = 1'b1;
                        rd_err_next  = ar_err;
                        prio_wr_next = 1'b1;
                        lat_cnt_next = LAT_LOAD;
                        state_next   = (RD_LATENCY > 0) ? RD_WAIT : RD_RESP;
                    end else if (grant_wr) begin
                        prio_wr_next = 1'b0;
                        if (m_axi_wvalid) begin
                            ram_we     = !aw_err;
                            bresp_next = aw_err ? RESP_SLVERR : RESP_OKAY;
                            state_next = WR_RESP;
                        end else begin
                            widx_next   = m_axi_awaddr[BYTE_SH +: IDX_W];
                            wr_err_next = aw_err;
                            state_next  = WR_DATA;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt_reg == 4'd0) begin
                    state_next = RD_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            RD_RESP: begin
                if (m_axi_rready) begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                m_axi_wready = 1'b1;
                ram_waddr    = widx_reg;
                if (m_axi_wvalid) begin
                    ram_we     = !wr_err_reg;
                    bresp_next = wr_err_reg ? RESP_SLVERR : RESP_OKAY;
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM output only changes on a new AR grant, so it stays stable through RD_RESP.
    assign m_axi_rvalid = (state_reg == RD_RESP);
    assign m_axi_rdata  = (m_axi_rvalid && !rd_err_reg) ? ram_rdata : '0;
    assign m_axi_rresp  = (m_axi_rvalid && rd_err_reg) ? RESP_SLVERR : RESP_OKAY;
    assign m_axi_bvalid = (state_reg == WR_RESP);
    assign m_axi_bresp  = m_axi_bvalid ? bresp_reg : RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised bench for axi_mem_responder checked against a word-array memory model.
module tb_axi_mem_responder;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DEPTH      = 256;
    localparam int RD_LATENCY = 3;
    localparam int TMO        = 100;

    logic              clk = 1'b0;
    logic              m_aresetn = 1'b0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [2:0]        arsize = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [2:0]        awsize = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    axi_mem_responder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk           (clk),
        .m_aresetn     (m_aresetn),
        .m_axi_araddr  (araddr),
        .m_axi_arsize  (arsize),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_awaddr  (awaddr),
        .m_axi_awsize  (awsize),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready)
    );

    // Reference model: word-addressed array of 4-byte words.
    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
        return ((addr / 4) >= DEPTH) || (size > 3'd2);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] size);
        if (model_err(addr, size)) return 32'h0;
        return model_mem[addr / 4];
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] size);
        return model_err(addr, size) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data, input logic [3:0] strb);
        if (!model_err(addr, size)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[addr / 4][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] size,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        data = '0; resp = '0; lat = 0;
        @(negedge clk);
        araddr = addr; arsize = size; arvalid = 1'b1;
        #1; n = 0;
        while (!arready && n < TMO) begin @(negedge clk); #1; n++; end
        if (!arready) begin
            tests_run++; tests_failed++;
            $display("FAIL ar_timeout: arready=%0b required 1", arready);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1 arvalid = 1'b0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < TMO);
        if (!rvalid) begin
            tests_run++; tests_failed++;
            $display("FAIL r_timeout: rvalid=%0b required 1", rvalid);
            return;
        end
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        $display("[TB] RD addr=%h size=%0d data=%h resp=%0d lat=%0d", addr, size, data, resp, lat);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                             input logic [3:0] strb, input int gap,
                             output logic [1:0] resp, output int blat);
        int n;
        resp = '0; blat = 0;
        @(negedge clk);
        awaddr = addr; awsize = size; awvalid = 1'b1;
        if (gap == 0) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
        #1; n = 0;
        while (!awready && n < TMO) begin @(negedge clk); #1; n++; end
        if (!awready) begin
            tests_run++; tests_failed++;
            $display("FAIL aw_timeout: awready=%0b required 1", awready);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(negedge clk);
            wdata = data; wstrb = strb; wvalid = 1'b1;
            #1; n = 0;
            while (!wready && n < TMO) begin @(negedge clk); #1; n++; end
            if (!wready) begin
                tests_run++; tests_failed++;
                $display("FAIL w_timeout: wready=%0b required 1", wready);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1 wvalid = 1'b0;
        end
        do begin @(negedge clk); blat++; end while (!bvalid && blat < TMO);
        if (!bvalid) begin
            tests_run++; tests_failed++;
            $display("FAIL b_timeout: bvalid=%0b required 1", bvalid);
            return;
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        $display("[TB] WR addr=%h size=%0d data=%h strb=%h gap=%0d resp=%0d", addr, size, data, strb, gap, resp);
    endtask

    task automatic pulse_reset;
        @(negedge clk); m_aresetn = 1'b0;
        repeat (2) @(negedge clk);
        m_aresetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        tests_run++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ar/aw/w/r/b=%b required 00000", {arready, awready, wready, rvalid, bvalid});
        end
        tests_run++;
        if ({rdata, rresp, bresp} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h rresp=%0d bresp=%0d required 0", rdata, rresp, bresp);
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk); m_aresetn = 1'b1; #1;
        tests_run++;
        if ({arready, awready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL release_first_edge: arready/awready=%b required 00", {arready, awready});
        end
        @(negedge clk); #1;
        tests_run++;
        if ({arready, awready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL release_second_edge: arready/awready=%b required 11", {arready, awready});
        end
    endtask

    task automatic test_basic;
        logic [31:0] d; logic [1:0] r; int lat;
        axi_write(32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 0, r, lat);
        model_write(32'h10, 3'd2, 32'hDEADBEEF, 4'hF);
        tests_run++;
        if (r !== 2'b00 || lat !== 1) begin
            tests_failed++;
            $display("FAIL basic_bresp: bresp=%0d blat=%0d required 0 and 1", r, lat);
        end
        axi_read(32'h10, 3'd2, d, r, lat);
        tests_run++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_read: rdata=%h rresp=%0d required deadbeef 0", d, r);
        end
        tests_run++;
        if (lat !== 1 + RD_LATENCY) begin
            tests_failed++;
            $display("FAIL read_latency: got %0d required %0d", lat, 1 + RD_LATENCY);
        end
        axi_read(32'h13, 3'd0, d, r, lat);
        tests_run++;
        if (d !== model_read(32'h13, 3'd0) || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL low_bits_ignored: rdata=%h required %h", d, model_read(32'h13, 3'd0));
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d; logic [1:0] r; int lat;
        axi_write(32'h0, 3'd2, 32'h11223344, 4'hF, 1, r, lat);
        model_write(32'h0, 3'd2, 32'h11223344, 4'hF);
        axi_write(32'h0, 3'd2, 32'hAABBCCDD, 4'b0101, 2, r, lat);
        model_write(32'h0, 3'd2, 32'hAABBCCDD, 4'b0101);
        axi_read(32'h0, 3'd2, d, r, lat);
        tests_run++;
        if (d !== 32'h11BB33DD || d !== model_read(32'h0, 3'd2)) begin
            tests_failed++;
            $display("FAIL strobe_merge: rdata=%h required 11bb33dd", d);
        end
        axi_write(32'h0, 3'd2, 32'h0, 4'h0, 0, r, lat);
        tests_run++;
        if (r !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_strobe_resp: bresp=%0d required 0", r);
        end
        axi_read(32'h0, 3'd2, d, r, lat);
        tests_run++;
        if (d !== 32'h11BB33DD) begin
            tests_failed++;
            $display("FAIL zero_strobe_data: rdata=%h required 11bb33dd", d);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic [1:0] r; int lat;
        axi_read(32'h400, 3'd2, d, r, lat);
        tests_run++;
        if (r !== 2'b10 || d !== 32'h0) begin
            tests_failed++;
            $display("FAIL oob_read: rresp=%0d rdata=%h required 2 0", r, d);
        end
        axi_write(32'h400, 3'd2, 32'hFFFFFFFF, 4'hF, 0, r, lat);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL oob_write_resp: bresp=%0d required 2", r);
        end
        axi_read(32'h0, 3'd2, d, r, lat);
        tests_run++;
        if (d !== model_read(32'h0, 3'd2)) begin
            tests_failed++;
            $display("FAIL oob_no_alias: rdata=%h required %h", d, model_read(32'h0, 3'd2));
        end
        axi_read(32'h0, 3'd3, d, r, lat);
        tests_run++;
        if (r !== 2'b10 || d !== 32'h0) begin
            tests_failed++;
            $display("FAIL size_err_read: rresp=%0d rdata=%h required 2 0", r, d);
        end
        axi_write(32'h0, 3'd3, 32'h0BADF00D, 4'hF, 1, r, lat);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL size_err_write: bresp=%0d required 2", r);
        end
        axi_read(32'h0, 3'd2, d, r, lat);
        tests_run++;
        if (d !== model_read(32'h0, 3'd2)) begin
            tests_failed++;
            $display("FAIL size_err_no_write: rdata=%h required %h", d, model_read(32'h0, 3'd2));
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] addr, d0;
        int n, lat;
        addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
        @(negedge clk);
        araddr = addr; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
        #1; n = 0;
        while (!arready && n < TMO) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1 arvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < TMO);
        tests_run++;
        if (lat !== 1 + RD_LATENCY || !rvalid) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d required %0d", lat, 1 + RD_LATENCY);
        end
        d0 = rdata;
        tests_run++;
        if (d0 !== model_read(addr, 3'd2)) begin
            tests_failed++;
            $display("FAIL bp_data: rdata=%h required %h", d0, model_read(addr, 3'd2));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (rvalid !== 1'b1 || rdata !== d0) begin
                tests_failed++;
                $display("FAIL bp_stable: rvalid=%0b rdata=%h required 1 %h", rvalid, rdata, d0);
            end
        end
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: rvalid=%0b required 0", rvalid);
        end
        $display("[TB] RD backpressure addr=%h data=%h", addr, d0);
    endtask

    task automatic test_arbitration;
        int order[$];
        logic ar_fire, aw_fire;
        logic [31:0] wa, wd;
        int n;
        pulse_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            wa = 32'($urandom_range(0, DEPTH - 1)) * 4;
            wd = $urandom;
            @(negedge clk);
            araddr = 32'($urandom_range(0, DEPTH - 1)) * 4; arsize = 3'd2; arvalid = 1'b1;
            awaddr = wa; awsize = 3'd2; awvalid = 1'b1;
            wdata = wd; wstrb = 4'hF; wvalid = 1'b1;
            rready = 1'b1; bready = 1'b1;
            n = 0;
            while ((arvalid || awvalid) && n < TMO) begin
                #1;
                ar_fire = arvalid && arready;
                aw_fire = awvalid && awready;
                @(posedge clk); #1;
                if (ar_fire) begin order.push_back(0); arvalid = 1'b0; end
                if (aw_fire) begin
                    order.push_back(1); awvalid = 1'b0; wvalid = 1'b0;
                    model_write(wa, 3'd2, wd, 4'hF);
                end
                @(negedge clk);
                n++;
            end
            arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
            repeat (10) @(negedge clk);
            rready = 1'b0; bready = 1'b0;
        end
        tests_run++;
        if (order.size() !== 4) begin
            tests_failed++;
            $display("FAIL arb_count: grants=%0d required 4", order.size());
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            tests_run++;
            if (order[i] !== i % 2) begin
                tests_failed++;
                $display("FAIL arb_order[%0d]: granted %s required %s", i,
                         order[i] ? "write" : "read", (i % 2) ? "write" : "read");
            end
            $display("[TB] ARB grant %0d = %s", i, order[i] ? "write" : "read");
        end
    endtask

    task automatic test_reset_midwrite;
        logic [31:0] addr, val, d; logic [1:0] r; int lat, n;
        addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
        val = $urandom;
        axi_write(addr, 3'd2, val, 4'hF, 0, r, lat);
        model_write(addr, 3'd2, val, 4'hF);
        @(negedge clk);
        awaddr = addr; awsize = 3'd2; awvalid = 1'b1; wvalid = 1'b0;
        #1; n = 0;
        while (!awready && n < TMO) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midwrite_wready: wready=%0b required 1", wready);
        end
        m_aresetn = 1'b0;
        wdata = ~val; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        tests_run++;
        if ({arready, awready, wready, rvalid, bvalid, rresp, bresp} !== 9'b0 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL midwrite_reset_outputs: ctrl=%b rdata=%h required 0",
                     {arready, awready, wready, rvalid, bvalid, rresp, bresp}, rdata);
        end
        @(negedge clk); wvalid = 1'b0;
        @(negedge clk); m_aresetn = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midwrite_no_resp: bvalid=%0b required 0", bvalid);
        end
        axi_read(addr, 3'd2, d, r, lat);
        tests_run++;
        if (d !== model_read(addr, 3'd2) || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL midwrite_unchanged: rdata=%h required %h", d, model_read(addr, 3'd2));
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addr, data, d; logic [3:0] strb; logic [1:0] r; int lat;
        for (int i = 0; i < 8; i++) begin
            addr = $urandom_range(0, DEPTH * 4 - 1);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            axi_write(addr, 3'd2, data, strb, 0, r, lat);
            model_write(addr, 3'd2, data, strb);
            axi_read(addr, 3'd2, d, r, lat);
            tests_run++;
            if (d !== model_read(addr, 3'd2)) begin
                tests_failed++;
                $display("FAIL b2b_read[%0d]: rdata=%h required %h", i, d, model_read(addr, 3'd2));
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] addr, data, d; logic [3:0] strb; logic [2:0] size; logic [1:0] r; int lat;
        for (int i = 0; i < 60; i++) begin
            addr = $urandom_range(0, 32'h4FF);
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, size, data, strb, $urandom_range(0, 2), r, lat);
                model_write(addr, size, data, strb);
                tests_run++;
                if (r !== model_resp(addr, size) || lat !== 1) begin
                    tests_failed++;
                    $display("FAIL rand_write[%0d]: bresp=%0d blat=%0d required %0d 1", i, r, lat, model_resp(addr, size));
                end
            end else begin
                axi_read(addr, size, d, r, lat);
                tests_run++;
                if (d !== model_read(addr, size) || r !== model_resp(addr, size)) begin
                    tests_failed++;
                    $display("FAIL rand_read[%0d]: rdata=%h rresp=%0d required %h %0d",
                             i, d, r, model_read(addr, size), model_resp(addr, size));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_backpressure();
        test_arbitration();
        test_reset_midwrite();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
